psg_control: RTL and testbench

//  Bus-side controller for the SN76489-style PSG. It decodes CPU byte writes into the

---
 rtl/psg_pkg.sv | 60 ++++++
 rtl/psg_clock_divider.sv | 37 +++
 rtl/psg_control.sv | 133 +++++++++++++
 tb/tb_psg_control.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// psg_pkg
//   Shared definitions for the PSG bus controller: channel and register-type
//   codes, bit positions inside a CPU write byte, the latch record, the READY
//   FSM state type and the "silent" attenuation value.
package psg_pkg;

  // Channel field of a latch byte; channel 3 is the noise generator.
  typedef enum logic [1:0] {
    CH_TONE0 = 2'd0,
    CH_TONE1 = 2'd1,
    CH_TONE2 = 2'd2,
    CH_NOISE = 2'd3
  } channel_t;

  // Register-type field of a latch byte.
  typedef enum logic {
    TYPE_TONE  = 1'b0,
    TYPE_ATTEN = 1'b1
  } reg_type_t;

  // Remembered target of data bytes.
  typedef struct packed {
    channel_t  ch;
    reg_type_t kind;
  } latch_t;

  // READY handshake states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ready_state_t;

  localparam int LATCH_BIT = 7;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;

  localparam logic [3:0] ATTEN_OFF = 4'hF;

  // Pull the channel/type fields out of a latch byte.
  function automatic latch_t decode_latch(input logic [7:0] b);
    latch_t l;
    l.ch   = channel_t'(b[CH_MSB:CH_LSB]);
    l.kind = reg_type_t'(b[TYPE_BIT]);
    return l;
  endfunction

  // Merge a write byte into a 10-bit tone period: latch bytes carry the low
  // nibble, data bytes carry the upper six bits (data[6] is ignored).
  function automatic logic [9:0] merge_period(input logic [9:0] old,
                                              input logic [7:0] b,
                                              input logic       is_latch);
    logic [9:0] p;
    p = old;
    if (is_latch) p[3:0] = b[3:0];
    else          p[9:4] = b[5:0];
    return p;
  endfunction

endpackage

// File: rtl/psg_clock_divider.sv
// psg_clock_divider
//   Free-running master-clock divider producing a one-cycle strobe every
//   CLOCK_DIV clocks. The count runs 0..CLOCK_DIV-1 and strobe is high while
//   the count equals CLOCK_DIV-1, so the first pulse lands CLOCK_DIV-1 cycles
//   after reset is released.
// Ports
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   strobe  out one-cycle pacing pulse for the tone/noise generators
module psg_clock_divider #(
  parameter int CLOCK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic strobe
);

  localparam int W = $clog2(CLOCK_DIV);
  localparam logic [W-1:0] LAST = W'(CLOCK_DIV - 1);
  localparam logic [W-1:0] PRE  = W'(CLOCK_DIV - 2);

  logic [W-1:0] count;

  // Count with explicit wrap so non-power-of-two dividers work. The strobe is
  // registered one count early, which lines it up with count == LAST while
  // keeping the output glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      strobe <= 1'b0;
    end else begin
      count  <= (count == LAST) ? '0 : count + 1'b1;
      strobe <= (count == PRE);
    end
  end

endmodule

// File: rtl/psg_control.sv
// psg_control
//   Bus-side controller for an SN76489-style PSG. Decodes CPU byte writes into
//   three 10-bit tone periods, the 3-bit noise control and four attenuations,
//   pulses noise_reset on noise-register writes, paces the generators with the
//   divider strobe and holds ready low for READY_CYCLES clocks after a write.
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   data, we_n             CPU write byte, active-low write enable (edge taken)
//   ready                  1 = can accept a write
//   strobe                 one-cycle pulse every CLOCK_DIV clocks
//   tone_period_0..2       tone channel periods (0 passed through as-is)
//   noise_ctrl             [2]=white/periodic, [1:0]=shift rate
//   noise_reset            one-cycle pulse after a noise_ctrl write
//   atten_0..atten_3       attenuations, 4'hF = silent, channel 3 = noise
module psg_control
  import psg_pkg::*;
#(
  parameter int CLOCK_DIV    = 16,
  parameter int READY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       we_n,
  output logic       ready,
  output logic       strobe,
  output logic [9:0] tone_period_0,
  output logic [9:0] tone_period_1,
  output logic [9:0] tone_period_2,
  output logic [2:0] noise_ctrl,
  output logic       noise_reset,
  output logic [3:0] atten_0,
  output logic [3:0] atten_1,
  output logic [3:0] atten_2,
  output logic [3:0] atten_3
);

  localparam int BW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
  localparam logic [BW-1:0] BUSY_LOAD = BW'(READY_CYCLES - 1);

  logic         we_n_q;
  latch_t       latch_q;
  ready_state_t state;
  logic [BW-1:0] busy_cnt;

  logic   accept;
  logic   is_latch;
  latch_t target;

  psg_clock_divider #(.CLOCK_DIV(CLOCK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (strobe)
  );

  // A write is a falling edge of we_n seen while idle; holding we_n low never
  // produces a second edge, and edges while busy are simply lost.
  assign accept   = we_n_q & ~we_n & ready;
  assign is_latch = data[LATCH_BIT];
  // Latch bytes address the register they name; data bytes reuse the latch.
  assign target   = is_latch ? decode_latch(data) : latch_q;

  // Register file: latch, tone periods, noise control and attenuations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_q       <= '{ch: CH_TONE0, kind: TYPE_TONE};
      tone_period_0 <= '0;
      tone_period_1 <= '0;
      tone_period_2 <= '0;
      noise_ctrl    <= '0;
      noise_reset   <= 1'b0;
      atten_0       <= ATTEN_OFF;
      atten_1       <= ATTEN_OFF;
      atten_2       <= ATTEN_OFF;
      atten_3       <= ATTEN_OFF;
    end else begin
      noise_reset <= 1'b0;
      if (accept) begin
        if (is_latch) latch_q <= target;
        if (target.kind == TYPE_ATTEN) begin
          case (target.ch)
            CH_TONE0: atten_0 <= data[3:0];
            CH_TONE1: atten_1 <= data[3:0];
            CH_TONE2: atten_2 <= data[3:0];
            CH_NOISE: atten_3 <= data[3:0];
          endcase
        end else begin
          case (target.ch)
            CH_TONE0: tone_period_0 <= merge_period(tone_period_0, data, is_latch);
            CH_TONE1: tone_period_1 <= merge_period(tone_period_1, data, is_latch);
            CH_TONE2: tone_period_2 <= merge_period(tone_period_2, data, is_latch);
            CH_NOISE: begin
              noise_ctrl  <= data[2:0];
              noise_reset <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // READY FSM and we_n edge history. The busy counter starts at
  // READY_CYCLES-1 and the return to IDLE happens on the edge where it is
  // already zero, giving exactly READY_CYCLES cycles of ready low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_n_q   <= 1'b1;
      state    <= ST_IDLE;
      ready    <= 1'b1;
      busy_cnt <= '0;
    end else begin
      we_n_q <= we_n;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_BUSY;
            ready    <= 1'b0;
            busy_cnt <= BUSY_LOAD;
          end
        end
        ST_BUSY: begin
          if (busy_cnt == '0) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psg_control.sv
// tb_psg_control
//   Directed bench for psg_control: reset values, divider strobe positions,
//   a table of register writes with hand-computed register images, and
//   hand-written sequences for dropped writes, held we_n and reset priority.
module tb_psg_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       we_n;
  logic       ready, strobe, noise_reset;
  logic [9:0] tone_period_0, tone_period_1, tone_period_2;
  logic [2:0] noise_ctrl;
  logic [3:0] atten_0, atten_1, atten_2, atten_3;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] tp0, tp1, tp2;
    logic [2:0] noise;
    logic       nr;
    logic [3:0] a0, a1, a2, a3;
  } vec_t;

  vec_t vecs[13];

  psg_control #(.CLOCK_DIV(16), .READY_CYCLES(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data          (data),
    .we_n          (we_n),
    .ready         (ready),
    .strobe        (strobe),
    .tone_period_0 (tone_period_0),
    .tone_period_1 (tone_period_1),
    .tone_period_2 (tone_period_2),
    .noise_ctrl    (noise_ctrl),
    .noise_reset   (noise_reset),
    .atten_0       (atten_0),
    .atten_1       (atten_1),
    .atten_2       (atten_2),
    .atten_3       (atten_3)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one write edge; returns just after the accepting clock edge.
  task automatic applyStimulus(input logic [7:0] b);
    data = b;
    we_n = 1'b0;
    tick();
    we_n = 1'b1;
  endtask

  // From just after an accept: check noise_reset drops and ready is low for
  // exactly 32 cycles (the sample right after the accept counts).
  task automatic waitIdle(input string name);
    int low;
    low = 0;
    if (!ready) low++;
    tick();
    checkOutput({name, " noise_reset 2nd cycle"}, 16'(noise_reset), 16'd0);
    while (!ready && low < 200) begin
      low++;
      tick();
    end
    checkOutput({name, " ready low cycles"}, 16'(low), 16'd32);
  endtask

  initial begin
    int low, falls;
    logic prevReady;

    vecs[0]  = '{8'h8E, 10'h00E, 10'h000, 10'h000, 3'd0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[1]  = '{8'h0F, 10'h0FE, 10'h000, 10'h000, 3'd0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[2]  = '{8'hE5, 10'h0FE, 10'h000, 10'h000, 3'd5, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[3]  = '{8'h02, 10'h0FE, 10'h000, 10'h000, 3'd2, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF};
    vecs[4]  = '{8'hD3, 10'h0FE, 10'h000, 10'h000, 3'd2, 1'b0, 4'hF, 4'hF, 4'h3, 4'hF};
    vecs[5]  = '{8'h07, 10'h0FE, 10'h000, 10'h000, 3'd2, 1'b0, 4'hF, 4'hF, 4'h7, 4'hF};
    vecs[6]  = '{8'hA1, 10'h0FE, 10'h001, 10'h000, 3'd2, 1'b0, 4'hF, 4'hF, 4'h7, 4'hF};
    vecs[7]  = '{8'h7F, 10'h0FE, 10'h3F1, 10'h000, 3'd2, 1'b0, 4'hF, 4'hF, 4'h7, 4'hF};
    vecs[8]  = '{8'hCA, 10'h0FE, 10'h3F1, 10'h00A, 3'd2, 1'b0, 4'hF, 4'hF, 4'h7, 4'hF};
    vecs[9]  = '{8'h55, 10'h0FE, 10'h3F1, 10'h15A, 3'd2, 1'b0, 4'hF, 4'hF, 4'h7, 4'hF};
    vecs[10] = '{8'hF0, 10'h0FE, 10'h3F1, 10'h15A, 3'd2, 1'b0, 4'hF, 4'hF, 4'h7, 4'h0};
    vecs[11] = '{8'h9C, 10'h0FE, 10'h3F1, 10'h15A, 3'd2, 1'b0, 4'hC, 4'hF, 4'h7, 4'h0};
    vecs[12] = '{8'h03, 10'h0FE, 10'h3F1, 10'h15A, 3'd2, 1'b0, 4'h3, 4'hF, 4'h7, 4'h0};

    // Reset values.
    rst_n = 1'b0;
    we_n  = 1'b1;
    data  = 8'h00;
    tick();
    tick();
    checkOutput("reset ready", 16'(ready), 16'd1);
    checkOutput("reset strobe", 16'(strobe), 16'd0);
    checkOutput("reset noise_reset", 16'(noise_reset), 16'd0);
    checkOutput("reset tp0", 16'(tone_period_0), 16'h000);
    checkOutput("reset tp1", 16'(tone_period_1), 16'h000);
    checkOutput("reset tp2", 16'(tone_period_2), 16'h000);
    checkOutput("reset noise", 16'(noise_ctrl), 16'd0);
    checkOutput("reset a0", 16'(atten_0), 16'hF);
    checkOutput("reset a1", 16'(atten_1), 16'hF);
    checkOutput("reset a2", 16'(atten_2), 16'hF);
    checkOutput("reset a3", 16'(atten_3), 16'hF);

    // Strobe cadence: cycle k is the k-th sample after the last reset edge.
    rst_n = 1'b1;
    for (int k = 0; k < 48; k++) begin
      checkOutput($sformatf("strobe cycle %0d", k), 16'(strobe),
                  16'((k % 16) == 15));
      tick();
    end

    // Table of writes with the full register image expected after each one.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("v%0d tp0", i), 16'(tone_period_0), 16'(vecs[i].tp0));
      checkOutput($sformatf("v%0d tp1", i), 16'(tone_period_1), 16'(vecs[i].tp1));
      checkOutput($sformatf("v%0d tp2", i), 16'(tone_period_2), 16'(vecs[i].tp2));
      checkOutput($sformatf("v%0d noise", i), 16'(noise_ctrl), 16'(vecs[i].noise));
      checkOutput($sformatf("v%0d noise_reset", i), 16'(noise_reset), 16'(vecs[i].nr));
      checkOutput($sformatf("v%0d a0", i), 16'(atten_0), 16'(vecs[i].a0));
      checkOutput($sformatf("v%0d a1", i), 16'(atten_1), 16'(vecs[i].a1));
      checkOutput($sformatf("v%0d a2", i), 16'(atten_2), 16'(vecs[i].a2));
      checkOutput($sformatf("v%0d a3", i), 16'(atten_3), 16'(vecs[i].a3));
      waitIdle($sformatf("v%0d", i));
    end

    // Second we_n edge 10 clocks into the busy window is dropped.
    data = 8'hA1;
    we_n = 1'b0;
    tick();
    low = 0;
    for (int k = 0; k < 40; k++) begin
      if (!ready) low++;
      if (k == 0) we_n = 1'b1;
      if (k == 9) begin
        data = 8'h85;
        we_n = 1'b0;
      end
      if (k == 12) we_n = 1'b1;
      tick();
    end
    checkOutput("drop ready low cycles", 16'(low), 16'd32);
    checkOutput("drop tp0 unchanged", 16'(tone_period_0), 16'h0FE);
    checkOutput("drop tp1", 16'(tone_period_1), 16'h3F1);

    // Holding we_n low for 100 clocks produces a single write.
    data = 8'h9A;
    we_n = 1'b0;
    prevReady = ready;
    falls = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (prevReady && !ready) falls++;
      prevReady = ready;
    end
    checkOutput("hold ready falls", 16'(falls), 16'd1);
    checkOutput("hold ready end", 16'(ready), 16'd1);
    checkOutput("hold a0", 16'(atten_0), 16'hA);
    we_n = 1'b1;
    tick();

    // Reset wins over a same-cycle write edge.
    data  = 8'hF5;
    we_n  = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("rst+we ready", 16'(ready), 16'd1);
    checkOutput("rst+we a3", 16'(atten_3), 16'hF);
    checkOutput("rst+we a0", 16'(atten_0), 16'hF);
    checkOutput("rst+we noise", 16'(noise_ctrl), 16'd0);
    checkOutput("rst+we noise_reset", 16'(noise_reset), 16'd0);
    checkOutput("rst+we tp0", 16'(tone_period_0), 16'h000);
    we_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of the busy window returns ready immediately.
    applyStimulus(8'h83);
    checkOutput("midbusy tp0 write", 16'(tone_period_0), 16'h003);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("midbusy ready low", 16'(ready), 16'd0);
    rst_n = 1'b0;
    tick();
    checkOutput("midbusy ready after reset", 16'(ready), 16'd1);
    checkOutput("midbusy tp0 after reset", 16'(tone_period_0), 16'h000);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
